// File: rtl/display_7seg_scan.sv
// Four-digit common-anode 7-segment scanner with a timed mode-word overlay.
// Outputs are registered from the current scan index and overlay state.
module display_7seg_scan #(
  parameter int unsigned REFRESH_DIV = 100000,
  parameter int unsigned WORD_HOLD   = 500
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] mode,
  input  logic [6:0] words_3,
  input  logic [6:0] words_2,
  input  logic [6:0] words_1,
  input  logic [6:0] words_0,
  input  logic [6:0] time_3,
  input  logic [6:0] time_2,
  input  logic [6:0] time_1,
  input  logic [6:0] time_0,
  input  logic       blank,
  output logic [6:0] seg,
  output logic [3:0] an,
  output logic       dp,
  output logic       showing_words
);

  localparam int unsigned PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int unsigned HW = (WORD_HOLD > 0) ? $clog2(WORD_HOLD + 1) : 1;

  typedef enum logic {
    SHOW_TIME  = 1'b0,
    SHOW_WORDS = 1'b1
  } state_t;

  state_t         state, state_nx;
  logic [HW-1:0]  hold_cnt, hold_nx;
  logic [PW-1:0]  presc;
  logic [1:0]     idx;
  logic [1:0]     mode_prev;
  logic           tick_c;
  logic           frame_end_c;
  logic [6:0]     pattern_c;

  assign tick_c      = (presc == PW'(REFRESH_DIV - 1));
  assign frame_end_c = tick_c && (idx == 2'd3);

  // Scan timebase; keeps running through blanking
  always_ff @(posedge clk) begin
    if (reset) begin
      presc     <= '0;
      idx       <= '0;
      mode_prev <= mode;
    end else begin
      presc     <= tick_c ? '0 : presc + PW'(1);
      idx       <= idx + 2'(tick_c);
      mode_prev <= mode;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= SHOW_TIME;
      hold_cnt <= '0;
    end else begin
      state    <= state_nx;
      hold_cnt <= hold_nx;
    end
  end

  // A mode change takes priority over a coincident frame_end
  always_comb begin
    state_nx = state;
    hold_nx  = hold_cnt;
    if (mode != mode_prev) begin
      if (mode != 2'b00) begin
        state_nx = SHOW_WORDS;
        hold_nx  = HW'(WORD_HOLD);
      end else begin
        state_nx = SHOW_TIME;
        hold_nx  = '0;
      end
    end else if ((state == SHOW_WORDS) && frame_end_c) begin
      if (hold_cnt == HW'(1)) begin
        state_nx = SHOW_TIME;
        hold_nx  = '0;
      end else begin
        hold_nx  = hold_cnt - HW'(1);
      end
    end
  end

  always_comb begin
    pattern_c = time_0;
    case (idx)
      2'd0: pattern_c = (state == SHOW_WORDS) ? words_0 : time_0;
      2'd1: pattern_c = (state == SHOW_WORDS) ? words_1 : time_1;
      2'd2: pattern_c = (state == SHOW_WORDS) ? words_2 : time_2;
      2'd3: pattern_c = (state == SHOW_WORDS) ? words_3 : time_3;
      default: pattern_c = time_0;
    endcase
  end

  // seg and an are loaded together so digits never ghost
  always_ff @(posedge clk) begin
    if (reset) begin
      seg           <= '1;
      an            <= '1;
      dp            <= 1'b1;
      showing_words <= 1'b0;
    end else begin
      showing_words <= (state == SHOW_WORDS);
      if (blank) begin
        seg <= '1;
        an  <= '1;
        dp  <= 1'b1;
      end else begin
        seg <= pattern_c;
        an  <= ~(4'b0001 << idx);
        dp  <= ~((idx == 2'd2) && (state == SHOW_TIME));
      end
    end
  end

endmodule

// File: tb/tb_display_7seg_scan.sv
// Bench for display_7seg_scan: directed and random stimulus against a
// cycle-count/deadline reference model of the scan and overlay.
module tb_display_7seg_scan;

  localparam int RD = 4;
  localparam int WH = 2;
  localparam int F  = 4 * RD;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] mode;
  logic [6:0] words_3, words_2, words_1, words_0;
  logic [6:0] time_3, time_2, time_1, time_0;
  logic       blank;
  logic [6:0] seg;
  logic [3:0] an;
  logic       dp;
  logic       showing_words;

  display_7seg_scan #(.REFRESH_DIV(RD), .WORD_HOLD(WH)) dut (
    .clk(clk), .reset(reset), .mode(mode),
    .words_3(words_3), .words_2(words_2), .words_1(words_1), .words_0(words_0),
    .time_3(time_3), .time_2(time_2), .time_1(time_1), .time_0(time_0),
    .blank(blank), .seg(seg), .an(an), .dp(dp), .showing_words(showing_words)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: k counts cycles since reset release; an overlay started
  // by a change at cycle c lasts through the WH-th frame end after c.
  int         k;
  int         last_change;
  logic [1:0] last_mode;
  logic       have_change;
  logic [1:0] mprev;

  function automatic int overlay_end(int c);
    int m;
    m = (c + 1) / F;
    return (m + WH - 1) * F + F - 1;
  endfunction

  function automatic logic [6:0] pick(int i, logic w);
    logic [6:0] p;
    case (i)
      0: p = w ? words_0 : time_0;
      1: p = w ? words_1 : time_1;
      2: p = w ? words_2 : time_2;
      default: p = w ? words_3 : time_3;
    endcase
    return p;
  endfunction

  task automatic chk(string tag, logic [6:0] obs, logic [6:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h cycle=%0d", tag, obs, exp, k);
    end
  endtask

  task automatic do_reset(int n);
    reset = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      chk("rst_an",  7'(an), 7'h0F);
      chk("rst_seg", seg, 7'h7F);
      chk("rst_dp",  7'(dp), 7'h01);
      chk("rst_sw",  7'(showing_words), 7'h00);
    end
    mprev       = mode;
    have_change = 1'b0;
    last_change = 0;
    last_mode   = 2'b00;
    k           = 0;
    reset       = 1'b0;
  endtask

  task automatic cycle();
    logic       w;
    int         i;
    logic [3:0] e_an;
    logic [6:0] e_seg;
    logic       e_dp;
    w = have_change && (last_mode != 2'b00) && (k <= overlay_end(last_change));
    if (mode != mprev) begin
      have_change = 1'b1;
      last_change = k;
      last_mode   = mode;
    end
    mprev = mode;
    i = (k / RD) % 4;
    if (blank) begin
      e_an  = 4'b1111;
      e_seg = 7'h7F;
      e_dp  = 1'b1;
    end else begin
      e_an    = 4'b1111;
      e_an[i] = 1'b0;
      e_seg   = pick(i, w);
      e_dp    = !((i == 2) && !w);
    end
    @(posedge clk); #1;
    chk("an",  7'(an), 7'(e_an));
    chk("seg", seg, e_seg);
    chk("dp",  7'(dp), 7'(e_dp));
    chk("showing_words", 7'(showing_words), 7'(w));
    k++;
  endtask

  task automatic run(int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    reset   = 1'b1;
    blank   = 1'b0;
    mode    = 2'b10;
    words_3 = 7'($urandom); words_2 = 7'($urandom);
    words_1 = 7'($urandom); words_0 = 7'($urandom);
    time_3  = 7'($urandom); time_2  = 7'($urandom);
    time_1  = 7'($urandom); time_0  = 7'($urandom);

    // Reset and basic scan
    do_reset(3);
    run(20);

    // Time digits
    time_3 = 7'h40; time_2 = 7'h79; time_1 = 7'h24; time_0 = 7'h30;
    run(2 * F);

    // Mode overlay 10 -> 11, through its expiry
    words_3 = 7'b0001001; words_2 = 7'b1111010;
    mode = 2'b11;
    run(3 * F + 8);

    // Restart one frame into an overlay, then cancel with 00
    mode = 2'b10;
    run(F);
    mode = 2'b01;
    run(F + 5);
    mode = 2'b00;
    run(10);

    // Blank for 6 cycles mid-scan
    mode = 2'b10;
    run(7);
    blank = 1'b1;
    run(6);
    blank = 1'b0;
    run(2 * F);

    // Reset during overlay with mode held
    mode = 2'b11;
    run(10);
    do_reset(2);
    run(3 * F);

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(19, 0) == 0) mode = 2'($urandom);
      if ($urandom_range(9, 0) == 0) blank = ~blank;
      if ($urandom_range(14, 0) == 0) begin
        words_3 = 7'($urandom); words_2 = 7'($urandom);
        words_1 = 7'($urandom); words_0 = 7'($urandom);
        time_3  = 7'($urandom); time_2  = 7'($urandom);
        time_1  = 7'($urandom); time_0  = 7'($urandom);
      end
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
